// File: rtl/spi_pkg.sv
// Shared definitions for the SPI host and the on-chip SPI responder: command
// bytes, request opcode encoding and host FSM state encoding.
package spi_pkg;

  localparam logic [7:0] CMD_READ   = 8'h03;
  localparam logic [7:0] CMD_WRITE  = 8'h02;
  localparam logic [7:0] CMD_STREAM = 8'h80;
  localparam logic [7:0] CMD_NOP    = 8'h00;

  typedef enum logic [1:0] {
    OP_READ   = 2'b00,
    OP_WRITE  = 2'b01,
    OP_STREAM = 2'b10,
    OP_NOP    = 2'b11
  } req_op_e;

  // ST_GAP is only reachable when the inter-sequence gap is enabled.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARG  = 3'd1,
    ST_DATA = 3'd2,
    ST_WAIT = 3'd3,
    ST_CAPT = 3'd4,
    ST_GAP  = 3'd5
  } host_state_e;

  typedef struct packed {
    req_op_e    op;
    logic [4:0] addr;
    logic [7:0] data;
  } host_req_t;

endpackage

// File: rtl/spi_host_if.sv
// Request/response bus between control logic (master) and the SPI host (slave).
interface spi_host_if;

  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic [4:0] req_addr;
  logic [7:0] req_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;

  modport master (
    output req_valid, req_op, req_addr, req_data,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_data,
    output req_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/spi_host.sv
// Byte-wide SPI command initiator: turns one request into READ/WRITE/STREAM byte
// sequences on mosi. Define SPI_HOST_NOP_GAP_EN to insert one idle GAP cycle after each sequence.
module spi_host
  import spi_pkg::*;
(
  input  logic       sclk,
  input  logic       rst_n,
  spi_host_if.slave  bus,
  output logic [7:0] mosi,
  output logic       cs,
  input  logic [7:0] miso
);

`ifdef SPI_HOST_NOP_GAP_EN
  localparam host_state_e LAST_NEXT = ST_GAP;
`else
  localparam host_state_e LAST_NEXT = ST_IDLE;
`endif

  host_state_e state_q, state_d;
  host_req_t   req_q, req_d;
  logic [7:0]  mosi_q, mosi_d;
  logic        cs_q, cs_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [7:0]  rsp_data_q, rsp_data_d;
  logic        accept;
  req_op_e     in_op;

  assign bus.req_ready = (state_q == ST_IDLE);
  assign accept        = bus.req_valid && bus.req_ready;
  assign in_op         = req_op_e'(bus.req_op);

  // State and output registers.
  always_ff @(posedge sclk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      req_q       <= '{op: OP_NOP, addr: 5'd0, data: 8'd0};
      mosi_q      <= CMD_NOP;
      cs_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'h00;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      mosi_q      <= mosi_d;
      cs_q        <= cs_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: a default assignment before the case keeps every path assigned,
    // so no latch is inferred.
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (in_op)
            OP_READ, OP_WRITE: state_d = ST_ARG;
            OP_STREAM:         state_d = ST_DATA;
            default:           state_d = ST_IDLE;
          endcase
        end
      end
      ST_ARG:  state_d = (req_q.op == OP_READ) ? ST_WAIT : ST_DATA;
      ST_DATA: state_d = LAST_NEXT;
      ST_WAIT: state_d = ST_CAPT;
      ST_CAPT: state_d = LAST_NEXT;
`ifdef SPI_HOST_NOP_GAP_EN
      ST_GAP:  state_d = ST_IDLE;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic: the byte computed here appears on mosi after the edge that
  // performs the matching state transition.
  always_comb begin
    req_d       = req_q;
    mosi_d      = CMD_NOP;
    cs_d        = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          req_d = '{op: in_op, addr: bus.req_addr, data: bus.req_data};
          case (in_op)
            OP_READ: begin
              mosi_d = CMD_READ;
              cs_d   = 1'b1;
            end
            OP_WRITE: begin
              mosi_d = CMD_WRITE;
              cs_d   = 1'b1;
            end
            OP_STREAM: begin
              mosi_d = CMD_STREAM;
              cs_d   = 1'b1;
            end
            default: ;
          endcase
        end
      end
      ST_ARG: begin
        cs_d   = 1'b1;
        mosi_d = (req_q.op == OP_READ) ? {3'b000, req_q.addr}
                                       : {4'b0000, req_q.addr[3:0]};
      end
      ST_DATA: begin
        cs_d   = 1'b1;
        mosi_d = req_q.data;
      end
      ST_CAPT: begin
        rsp_data_d  = miso;
        rsp_valid_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign mosi          = mosi_q;
  assign cs            = cs_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_spi_host.sv
// Self-checking bench for spi_host with a behavioural SPI responder and a
// sequence-level reference model producing the expected per-cycle trace.
module tb_spi_host;
  import spi_pkg::*;

`ifdef SPI_HOST_NOP_GAP_EN
  localparam bit GAP_EN = 1'b1;
`else
  localparam bit GAP_EN = 1'b0;
`endif

  logic       sclk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] mosi;
  logic [7:0] miso;
  logic       cs;

  spi_host_if bus();

  spi_host dut (
    .sclk  (sclk),
    .rst_n (rst_n),
    .bus   (bus.slave),
    .mosi  (mosi),
    .cs    (cs),
    .miso  (miso)
  );

  always #5 sclk = ~sclk;

  // Responder: 16-byte memory, stream-match counter against mem[0] under mask mem[1].
  logic [7:0] r_mem [16];
  logic [7:0] r_res;
  logic [3:0] r_addr;
  int         r_st;

  always @(posedge sclk) begin
    if (!rst_n) begin
      r_st   <= 0;
      miso   <= 8'h00;
      r_res  <= 8'h00;
      r_addr <= 4'h0;
      for (int i = 0; i < 16; i++) r_mem[i] <= 8'h00;
    end else if (cs) begin
      case (r_st)
        0: begin
          if (mosi == CMD_READ)        r_st <= 1;
          else if (mosi == CMD_WRITE)  r_st <= 2;
          else if (mosi == CMD_STREAM) r_st <= 4;
        end
        1: begin
          miso <= mosi[4] ? r_res : r_mem[mosi[3:0]];
          r_st <= 0;
        end
        2: begin
          r_addr <= mosi[3:0];
          r_st   <= 3;
        end
        3: begin
          r_mem[r_addr] <= mosi;
          r_st          <= 0;
        end
        4: begin
          if (((mosi ^ r_mem[0]) & r_mem[1]) == 8'h00) r_res <= r_res + 8'd1;
          r_st <= 0;
        end
        default: r_st <= 0;
      endcase
    end
  end

  // Reference model and expected per-cycle trace.
  typedef struct {
    logic       v;
    logic [1:0] op;
    logic [4:0] addr;
    logic [7:0] data;
    logic [7:0] e_mosi;
    logic       e_cs;
    logic       e_rdy;
    logic       e_rv;
    logic [7:0] e_rd;
  } cyc_t;

  cyc_t       tr[$];
  int         prev_start;
  logic [7:0] mdl_mem [16];
  logic [7:0] mdl_res;
  int         errors = 0;
  int         checks = 0;

  task automatic model_clear();
    for (int i = 0; i < 16; i++) mdl_mem[i] = 8'h00;
    mdl_res    = 8'h00;
    prev_start = 0;
    tr.delete();
  endtask

  task automatic add_out(input logic [7:0] m, input logic c, input logic rdy,
                         input logic rv, input logic [7:0] rd);
    cyc_t e;
    e = '{v: 1'b0, op: 2'b11, addr: 5'd0, data: 8'd0,
          e_mosi: m, e_cs: c, e_rdy: rdy, e_rv: rv, e_rd: rd};
    tr.push_back(e);
  endtask

  task automatic add_idle();
    add_out(8'h00, 1'b0, 1'b1, 1'b0, 8'h00);
  endtask

  // Appends one request: the cycle(s) presenting it, then the bytes it must produce.
  task automatic add_req(input logic [1:0] op, input logic [4:0] addr,
                         input logic [7:0] data, input int gap, input bit hold);
    cyc_t       e;
    int         first;
    logic [7:0] rd;
    if (tr.size() == 0) add_idle();
    repeat (gap) add_idle();
    first = (hold && gap == 0) ? prev_start : tr.size() - 1;
    for (int i = first; i < tr.size(); i++) begin
      e      = tr[i];
      e.v    = 1'b1;
      e.op   = op;
      e.addr = addr;
      e.data = data;
      tr[i]  = e;
    end
    prev_start = tr.size();
    case (op)
      2'b00: begin
        rd = addr[4] ? mdl_res : mdl_mem[addr[3:0]];
        add_out(8'h03, 1'b1, 1'b0, 1'b0, 8'h00);
        add_out({3'b000, addr}, 1'b1, 1'b0, 1'b0, 8'h00);
        add_out(8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        add_out(8'h00, 1'b0, !GAP_EN, 1'b1, rd);
      end
      2'b01: begin
        mdl_mem[addr[3:0]] = data;
        add_out(8'h02, 1'b1, 1'b0, 1'b0, 8'h00);
        add_out({4'b0000, addr[3:0]}, 1'b1, 1'b0, 1'b0, 8'h00);
        add_out(data, 1'b1, !GAP_EN, 1'b0, 8'h00);
      end
      2'b10: begin
        if (((data ^ mdl_mem[0]) & mdl_mem[1]) == 8'h00) mdl_res = mdl_res + 8'd1;
        add_out(8'h80, 1'b1, 1'b0, 1'b0, 8'h00);
        add_out(data, 1'b1, !GAP_EN, 1'b0, 8'h00);
      end
      default: add_idle();
    endcase
    if (GAP_EN && op != 2'b11) add_idle();
  endtask

  task automatic run_trace(input string name);
    add_idle();
    add_idle();
    for (int i = 0; i < tr.size(); i++) begin
      @(posedge sclk);
      #1;
      checks++;
      if (mosi !== tr[i].e_mosi) begin
        errors++;
        $display("FAIL %s cyc %0d mosi got %h exp %h", name, i, mosi, tr[i].e_mosi);
      end
      checks++;
      if (cs !== tr[i].e_cs) begin
        errors++;
        $display("FAIL %s cyc %0d cs got %b exp %b", name, i, cs, tr[i].e_cs);
      end
      checks++;
      if (bus.req_ready !== tr[i].e_rdy) begin
        errors++;
        $display("FAIL %s cyc %0d req_ready got %b exp %b", name, i, bus.req_ready, tr[i].e_rdy);
      end
      checks++;
      if (bus.rsp_valid !== tr[i].e_rv) begin
        errors++;
        $display("FAIL %s cyc %0d rsp_valid got %b exp %b", name, i, bus.rsp_valid, tr[i].e_rv);
      end
      if (tr[i].e_rv) begin
        checks++;
        if (bus.rsp_data !== tr[i].e_rd) begin
          errors++;
          $display("FAIL %s cyc %0d rsp_data got %h exp %h", name, i, bus.rsp_data, tr[i].e_rd);
        end
      end
      bus.req_valid = tr[i].v;
      bus.req_op    = tr[i].op;
      bus.req_addr  = tr[i].addr;
      bus.req_data  = tr[i].data;
    end
    bus.req_valid = 1'b0;
    tr.delete();
    prev_start = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge sclk);
    #1;
    checks++;
    if (mosi !== 8'h00) begin errors++; $display("FAIL reset mosi got %h exp 00", mosi); end
    checks++;
    if (cs !== 1'b0) begin errors++; $display("FAIL reset cs got %b exp 0", cs); end
    checks++;
    if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset rsp_valid got %b exp 0", bus.rsp_valid); end
    checks++;
    if (bus.rsp_data !== 8'h00) begin errors++; $display("FAIL reset rsp_data got %h exp 00", bus.rsp_data); end
    checks++;
    if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset req_ready got %b exp 1", bus.req_ready); end
    rst_n = 1'b1;
    model_clear();
  endtask

  task automatic test_write_stream_read();
    add_req(2'b01, 5'h03, 8'hA5, 0, 1'b0);
    add_req(2'b10, 5'h00, 8'h41, 0, 1'b1);
    add_req(2'b00, 5'h03, 8'h00, 0, 1'b0);
    run_trace("write_stream_read");
  endtask

  task automatic test_match();
    add_req(2'b01, 5'h00, 8'h41, 1, 1'b0);
    add_req(2'b01, 5'h01, 8'hFF, 0, 1'b1);
    add_req(2'b10, 5'h00, 8'h41, 0, 1'b1);
    add_req(2'b10, 5'h00, 8'h42, 2, 1'b0);
    add_req(2'b01, 5'h01, 8'hF0, 0, 1'b0);
    add_req(2'b10, 5'h00, 8'h4E, 0, 1'b1);
    add_req(2'b00, 5'h10, 8'h00, 0, 1'b1);
    run_trace("match");
  endtask

  task automatic test_nop();
    add_req(2'b11, 5'h07, 8'h5A, 1, 1'b0);
    add_req(2'b11, 5'h1F, 8'hFF, 0, 1'b1);
    add_req(2'b00, 5'h00, 8'h00, 0, 1'b1);
    add_req(2'b11, 5'h00, 8'h00, 0, 1'b1);
    run_trace("nop");
  endtask

  task automatic test_reset_mid_read();
    @(posedge sclk);
    #1;
    bus.req_valid = 1'b1;
    bus.req_op    = 2'b00;
    bus.req_addr  = 5'h03;
    bus.req_data  = 8'h00;
    @(posedge sclk);
    #1;
    bus.req_valid = 1'b0;
    checks++;
    if (mosi !== 8'h03) begin errors++; $display("FAIL mid_reset cmd mosi got %h exp 03", mosi); end
    @(posedge sclk);
    #1;
    rst_n = 1'b0;
    @(posedge sclk);
    #1;
    rst_n = 1'b1;
    checks++;
    if (mosi !== 8'h00) begin errors++; $display("FAIL mid_reset mosi got %h exp 00", mosi); end
    checks++;
    if (cs !== 1'b0) begin errors++; $display("FAIL mid_reset cs got %b exp 0", cs); end
    checks++;
    if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL mid_reset req_ready got %b exp 1", bus.req_ready); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL mid_reset cyc %0d rsp_valid got %b exp 0", i, bus.rsp_valid);
      end
      @(posedge sclk);
      #1;
    end
    model_clear();
  endtask

  task automatic test_random(input int n, input bit b2b);
    logic [1:0] op;
    logic [7:0] data;
    for (int i = 0; i < n; i++) begin
      op   = 2'($urandom_range(0, 3));
      data = 8'($urandom);
      if ($urandom_range(0, 3) == 0) data = mdl_mem[0];
      if (b2b) add_req(op, 5'($urandom), data, 0, 1'b1);
      else     add_req(op, 5'($urandom), data, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end
    add_req(2'b00, 5'h10, 8'h00, 0, 1'b0);
    run_trace(b2b ? "back_to_back" : "random");
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_op    = 2'b11;
    bus.req_addr  = 5'd0;
    bus.req_data  = 8'd0;
    model_clear();
    test_reset();
    test_write_stream_read();
    test_match();
    test_nop();
    test_reset_mid_read();
    test_random(150, 1'b0);
    test_random(60, 1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
